// File: rtl/green_key_pkg.sv
// Shared defaults, background-mode encodings and statistics FSM states
// for the green-screen key mixer.
package green_key_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int OUT_W_DEF  = 10;
  localparam int CNT_W_DEF  = 24;

  typedef enum logic [1:0] {
    BG_BLACK  = 2'b00,
    BG_BLUE   = 2'b01,
    BG_CHECK  = 2'b10,
    BG_BYPASS = 2'b11
  } bg_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } stat_state_e;

endpackage

// File: rtl/key_frame_stats.sv
// Per-frame keyed/total pixel counters, driven by the stage-2 aligned
// frame, valid and key signals of the mixer pipeline.
module key_frame_stats
  import green_key_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             frame_i,
  input  logic             valid_i,
  input  logic             key_i,
  output logic [CNT_W-1:0] key_cnt_o,
  output logic [CNT_W-1:0] pix_cnt_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  stat_state_e      state_q, state_d;
  logic [CNT_W-1:0] kcnt_q, kcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] kout_q, kout_d;
  logic [CNT_W-1:0] pout_q, pout_d;
  logic             fprev_q;
  logic             armed_q, armed_d;
  logic [1:0]       fill_q, fill_d;
  logic             rise, fall;

  // frame_i is only genuine two edges after reset; arm on a genuine low
  // so a frame already running at release is never counted.
  assign fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
  assign armed_d = armed_q | ((fill_q == 2'd2) & ~frame_i);
  assign rise    = armed_q & frame_i & ~fprev_q;
  assign fall    = fprev_q & ~frame_i;

  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    pcnt_d  = pcnt_q;
    kout_d  = kout_q;
    pout_d  = pout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_COUNT;
          kcnt_d  = '0;
          pcnt_d  = '0;
        end
      end
      ST_COUNT: begin
        if (fall) begin
          state_d = ST_DONE;
          kout_d  = kcnt_q;
          pout_d  = pcnt_q;
        end else begin
          if (valid_i && pcnt_q != CMAX) pcnt_d = pcnt_q + 1'b1;
          if (key_i && kcnt_q != CMAX)   kcnt_d = kcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (rise) begin
          state_d = ST_COUNT;
          kcnt_d  = '0;
          pcnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      kcnt_q  <= '0;
      pcnt_q  <= '0;
      kout_q  <= '0;
      pout_q  <= '0;
      fprev_q <= 1'b0;
      armed_q <= 1'b0;
      fill_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      pcnt_q  <= pcnt_d;
      kout_q  <= kout_d;
      pout_q  <= pout_d;
      fprev_q <= frame_i;
      armed_q <= armed_d;
      fill_q  <= fill_d;
    end
  end

  assign key_cnt_o = kout_q;
  assign pix_cnt_o = pout_q;
  assign done_o    = (state_q == ST_DONE);

endmodule

// File: rtl/green_key_mixer.sv
// Three-stage chroma-key pixel mixer: green-dominant camera pixels are
// replaced by a selectable background; per-frame key statistics.
module green_key_mixer
  import green_key_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int CELL_LOG2 = 5,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [DATA_W-1:0] iRed,
  input  logic [DATA_W-1:0] iGreen,
  input  logic [DATA_W-1:0] iBlue,
  input  logic              iDataValid,
  input  logic              iFrameValid,
  input  logic [15:0]       iX_Counter,
  input  logic [15:0]       iY_Counter,
  input  logic [7:0]        iThreshold,
  input  logic [7:0]        iMinGreen,
  input  logic [1:0]        iBgMode,
  output logic [OUT_W-1:0]  oRed,
  output logic [OUT_W-1:0]  oGreen,
  output logic [OUT_W-1:0]  oBlue,
  output logic              oDataValid,
  output logic              oKeyed,
  output logic [CNT_W-1:0]  oKeyCount,
  output logic [CNT_W-1:0]  oPixCount,
  output logic              oFrameDone
);

  localparam int EW = DATA_W + 1;

  logic [DATA_W-1:0] max_c;
  logic [11:0]       thr_c, min_c;
  logic              chk_c;
  logic              unused_coord;

  logic [EW-1:0]     g1_q, m1_q, t1_q, n1_q;
  logic [OUT_W-1:0]  rt1_q, gt1_q, bt1_q;
  logic              v1_q, f1_q, chk1_q;
  bg_mode_e          mode1_q;

  logic              key_c;
  logic [OUT_W-1:0]  rt2_q, gt2_q, bt2_q;
  logic              v2_q, f2_q, key2_q, chk2_q;
  bg_mode_e          mode2_q;

  logic [OUT_W-1:0]  r3_d, g3_d, b3_d;
  logic [OUT_W-1:0]  r3_q, g3_q, b3_q;
  logic              v3_q, k3_q;

  assign max_c = (iRed > iBlue) ? iRed : iBlue;
  assign thr_c = {iThreshold, 4'b0000};
  assign min_c = {iMinGreen, 4'b0000};
  assign chk_c = iX_Counter[CELL_LOG2] ^ iY_Counter[CELL_LOG2];
  assign unused_coord = ^{iX_Counter, iY_Counter};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      g1_q    <= '0;
      m1_q    <= '0;
      t1_q    <= '0;
      n1_q    <= '0;
      rt1_q   <= '0;
      gt1_q   <= '0;
      bt1_q   <= '0;
      v1_q    <= 1'b0;
      f1_q    <= 1'b0;
      chk1_q  <= 1'b0;
      mode1_q <= BG_BLACK;
    end else begin
      g1_q    <= EW'(iGreen);
      m1_q    <= EW'(max_c);
      t1_q    <= EW'(thr_c);
      n1_q    <= EW'(min_c);
      rt1_q   <= iRed[DATA_W-1 -: OUT_W];
      gt1_q   <= iGreen[DATA_W-1 -: OUT_W];
      bt1_q   <= iBlue[DATA_W-1 -: OUT_W];
      v1_q    <= iDataValid;
      f1_q    <= iFrameValid;
      chk1_q  <= chk_c;
      mode1_q <= bg_mode_e'(iBgMode);
    end
  end

  // One extra bit holds max(R,B)+T without wrapping.
  assign key_c = v1_q && (mode1_q != BG_BYPASS) &&
                 (g1_q > m1_q + t1_q) && (g1_q >= n1_q);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rt2_q   <= '0;
      gt2_q   <= '0;
      bt2_q   <= '0;
      v2_q    <= 1'b0;
      f2_q    <= 1'b0;
      key2_q  <= 1'b0;
      chk2_q  <= 1'b0;
      mode2_q <= BG_BLACK;
    end else begin
      rt2_q   <= rt1_q;
      gt2_q   <= gt1_q;
      bt2_q   <= bt1_q;
      v2_q    <= v1_q;
      f2_q    <= f1_q;
      key2_q  <= key_c;
      chk2_q  <= chk1_q;
      mode2_q <= mode1_q;
    end
  end

  always_comb begin
    r3_d = '0;
    g3_d = '0;
    b3_d = '0;
    if (key2_q) begin
      unique case (mode2_q)
        BG_BLUE: b3_d = '1;
        BG_CHECK: begin
          if (chk2_q) begin
            r3_d = '1;
            g3_d = '1;
            b3_d = '1;
          end
        end
        default: ;
      endcase
    end else if (v2_q) begin
      r3_d = rt2_q;
      g3_d = gt2_q;
      b3_d = bt2_q;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r3_q <= '0;
      g3_q <= '0;
      b3_q <= '0;
      v3_q <= 1'b0;
      k3_q <= 1'b0;
    end else begin
      r3_q <= r3_d;
      g3_q <= g3_d;
      b3_q <= b3_d;
      v3_q <= v2_q;
      k3_q <= key2_q;
    end
  end

  assign oRed       = r3_q;
  assign oGreen     = g3_q;
  assign oBlue      = b3_q;
  assign oDataValid = v3_q;
  assign oKeyed     = k3_q;

  key_frame_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk_i    (iCLK),
    .rst_ni   (iRST_N),
    .frame_i  (f2_q),
    .valid_i  (v2_q),
    .key_i    (key2_q),
    .key_cnt_o(oKeyCount),
    .pix_cnt_o(oPixCount),
    .done_o   (oFrameDone)
  );

endmodule

// File: doc/green_key_mixer.md
GREEN_KEY_MIXER -- requirements
Module: green_key_mixer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, meaning input colour channel width.
REQ-002 The block SHALL have parameter OUT_W, default 10, meaning output colour channel width for the VGA controller.
REQ-003 The block SHALL have parameter CELL_LOG2, default 5, meaning checkerboard cell size of 2^CELL_LOG2 pixels.
REQ-004 The block SHALL have parameter CNT_W, default 24, meaning width of the per-frame statistic counters.
REQ-005 iCLK  in  1  pixel clock; one clock only; reset is asynchronous and active-low (iRST_N).
REQ-006 iRST_N  in  1  asynchronous active-low reset.
REQ-007 iRed, iGreen, iBlue  in  DATA_W each  demosaiced pixel from the RAW-to-RGB stage.
REQ-008 iDataValid  in  1  pixel qualifier.
REQ-009 iFrameValid  in  1  registered camera FVAL.
REQ-010 iX_Counter, iY_Counter  in  16 each  pixel coordinates from capture.
REQ-011 iThreshold  in  8  green dominance margin.
REQ-012 iMinGreen  in  8  minimum green level.
REQ-013 iBgMode  in  2  00 black, 01 blue, 10 checkerboard, 11 bypass.
REQ-014 oRed, oGreen, oBlue  out  OUT_W each  mixed pixel.
REQ-015 oDataValid  out  1  output qualifier.
REQ-016 oKeyed  out  1  current output pixel was replaced.
REQ-017 oKeyCount, oPixCount  out  CNT_W each  keyed and total valid pixels of the last completed frame.
REQ-018 oFrameDone  out  1  one-cycle pulse when the counts update.

Function
REQ-019 The pixel path SHALL be a fixed 3-stage pipeline; outputs correspond to inputs sampled 3 iCLK edges earlier, with no stall or backpressure.
REQ-020 Stage 1 SHALL register G, M = max(R,B), T = {iThreshold,4'b0000} and N = {iMinGreen,4'b0000}, zero-extended to DATA_W+1 bits, plus valid, frame and coordinates.
REQ-021 Stage 2 SHALL compute key = valid AND (iBgMode != 11) AND (G > M + T) AND (G >= N), using DATA_W+1-bit arithmetic with no overflow.
REQ-022 Stage 3 SHALL output the background when key = 1, else the camera pixel truncated to bits [DATA_W-1:DATA_W-OUT_W].
REQ-023 The background SHALL be 0/0/0 for mode 00 and 0/0/all-ones for mode 01.
REQ-024 For mode 10, the background SHALL be white (all ones) when X[CELL_LOG2] XOR Y[CELL_LOG2] = 1, else black.
REQ-025 When the delayed valid is 0, outputs SHALL be zero colour with oKeyed = 0.
REQ-026 iBgMode, iThreshold and iMinGreen SHALL be sampled per pixel at stage 1; a mid-frame change affects only later pixels.
REQ-027 The statistics FSM SHALL run on the stage-2-aligned frame and key signals, with states IDLE, COUNT and DONE.
REQ-028 IDLE SHALL go to COUNT on the rising edge of the delayed frame, clearing both counters.
REQ-029 In COUNT, each valid pixel SHALL increment pix_cnt and each keyed pixel SHALL increment key_cnt, both saturating at 2^CNT_W-1.
REQ-030 COUNT SHALL go to DONE on the falling edge of the delayed frame, regardless of line position.
REQ-031 DONE SHALL last one cycle, latch oKeyCount/oPixCount, pulse oFrameDone, and go to IDLE.
REQ-032 If a new rising frame edge coincides with DONE, the FSM SHALL go directly to COUNT with cleared counters.
REQ-033 A valid pixel on the falling-edge cycle SHALL NOT be counted.

Reset
REQ-034 Asserting iRST_N low SHALL immediately clear all pipeline registers, counters, oKeyCount, oPixCount, oFrameDone, oKeyed, oDataValid and colour outputs to 0, and set the FSM to IDLE.
REQ-035 A frame already in progress at reset release SHALL NOT be counted; counting starts at the next rising frame edge.

Structure
REQ-036 Package green_key_pkg SHALL hold the DATA_W/OUT_W/CNT_W defaults, the iBgMode encodings and the FSM state enumeration.
REQ-037 The statistics FSM and counters SHALL be sub-module key_frame_stats; the pixel pipeline SHALL stay in green_key_mixer.

Verification
REQ-038 Scenario 1: in mode 00 with threshold 16 and min green 32, input R=100, G=900, B=200 -> 3 cycles later oKeyed=1 and output 0/0/0; input G=400 -> output 25/100/50 (>>2), oKeyed=0.
REQ-039 Scenario 2 (boundary): with T=256, M=200 and N=0, G=456 -> not keyed; G=457 -> keyed.
REQ-040 Scenario 3: in mode 10 with CELL_LOG2=5, keyed pixels at (31,0) -> black, (32,0) -> white, (32,32) -> black.
REQ-041 Scenario 4: a frame of 4 lines x 64 valid pixels with 100 keyed -> after the frame falls, oFrameDone pulses once with oPixCount=256 and oKeyCount=100.
REQ-042 Scenario 5: in mode 11 with all pixels green -> oKeyed stays 0, pass-through colours, oKeyCount=0.
REQ-043 Scenario 6: iRST_N low mid-frame -> outputs zero the same cycle; after release mid-frame, no oFrameDone until a full subsequent frame completes.
